// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory load controller.
// Provides the controller state encoding, the NOP instruction driven to a
// stalled core, and the byte step between consecutive instruction words.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_ctrl_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive 32-bit instruction words.
  localparam int unsigned WORD_STEP = 4;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Program-loader word stream between a loader (master) and the instruction
// memory load controller (slave).
//   ld_valid : loader word valid          (master -> slave)
//   ld_data  : loader word                (master -> slave)
//   ld_ready : controller accepts a word  (slave  -> master)
interface imem_load_ctrl_if #(
  parameter int DATA_W = 32
);

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    output ld_ready
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction memory load controller.
// Shares the single-port, word-addressed instruction memory between a
// sequential program loader (writes from address 0) and core instruction
// fetch. While a load is pending or in progress the core is stalled and fed
// NOPs; in RUN the fetch path is purely combinational (zero added latency).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load_start        : one-cycle request to start a load (ignored in LOAD)
//   load_len          : words to load, 0 means 2^LEN_W
//   ld                : loader stream (slave modport: valid/data in, ready out)
//   load_busy         : high while loading
//   load_done         : one-cycle pulse in the first RUN cycle after a load
//   core_pc           : core fetch byte address (bits [1:0] ignored)
//   core_instr        : instruction delivered to the core
//   core_stall        : core must hold its PC
//   mem_addr/we/wdata : instruction memory port
//   mem_rdata         : combinational memory read data
module imem_load_ctrl #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR,
  parameter bit          BOOT_LOAD = 1'b1,
  parameter int          LEN_W     = ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [LEN_W-1:0]  load_len,
  imem_load_ctrl_if.slave   ld,
  output logic              load_busy,
  output logic              load_done,
  input  logic [ADDR_W-1:0] core_pc,
  output logic [DATA_W-1:0] core_instr,
  output logic              core_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import imem_pkg::*;

  localparam imem_ctrl_state_t RESET_STATE = BOOT_LOAD ? IDLE : RUN;
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_STEP);
  localparam logic [LEN_W:0]    WL_ONE     = (LEN_W + 1)'(1);

  imem_ctrl_state_t  state_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [LEN_W:0]    words_left_r;
  logic              load_done_r;
  logic [LEN_W:0]    len_init_s;
  logic              unused_pc_s;

  // Fetch addresses are word aligned; the low PC bits are deliberately dropped.
  assign unused_pc_s = ^core_pc[1:0];

  // Word count for a new load; a zero length field encodes a full 2^LEN_W load.
  always_comb begin
    len_init_s = '0;
    if (load_len == '0) begin
      len_init_s = {1'b1, {LEN_W{1'b0}}};
    end else begin
      len_init_s = {1'b0, load_len};
    end
  end

  // Controller FSM with write-address and remaining-word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RESET_STATE;
      wr_addr_r    <= '0;
      words_left_r <= '0;
      load_done_r  <= 1'b0;
    end else begin
      load_done_r <= 1'b0;
      case (state_r)
        IDLE, RUN: begin
          if (load_start) begin
            state_r      <= LOAD;
            wr_addr_r    <= '0;
            words_left_r <= len_init_s;
          end
        end
        LOAD: begin
          // ld_ready is constantly high in LOAD, so ld_valid alone is an accept.
          if (ld.ld_valid) begin
            // Address wraps modulo 2^ADDR_W after a full-size load.
            wr_addr_r    <= wr_addr_r + ADDR_STEP;
            words_left_r <= words_left_r - WL_ONE;
            if (words_left_r == WL_ONE) begin
              state_r     <= RUN;
              load_done_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= RESET_STATE;
        end
      endcase
    end
  end

  assign load_done = load_done_r;

  // Memory port and core-side mux, selected by the registered state.
  always_comb begin
    ld.ld_ready = 1'b0;
    load_busy   = 1'b0;
    core_stall  = 1'b1;
    core_instr  = NOP_INSTR[DATA_W-1:0];
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (state_r)
      IDLE: begin
        core_stall = 1'b1;
      end
      LOAD: begin
        ld.ld_ready = 1'b1;
        load_busy   = 1'b1;
        mem_addr    = wr_addr_r;
        mem_we      = ld.ld_valid;
        mem_wdata   = ld.ld_data;
      end
      RUN: begin
        core_stall = 1'b0;
        core_instr = mem_rdata;
        mem_addr   = {core_pc[ADDR_W-1:2], 2'b00};
      end
      default: begin
        core_stall = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  localparam int          ADDR_W = 8;
  localparam int          DATA_W = 32;
  localparam int          LEN_W  = 6;
  localparam int          NWORDS = 64;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [LEN_W-1:0]  load_len;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W-1:0] core_pc;
  logic [DATA_W-1:0] core_instr;
  logic              core_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  imem_load_ctrl_if #(.DATA_W(DATA_W)) ldif ();

  imem_load_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP), .BOOT_LOAD(1'b1), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .ld(ldif.slave), .load_busy(load_busy), .load_done(load_done),
    .core_pc(core_pc), .core_instr(core_instr), .core_stall(core_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // External instruction memory: synchronous write, combinational read.
  logic [31:0] tb_mem [NWORDS];
  always @(posedge clk) if (mem_we === 1'b1) tb_mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr[7:2]];

  // Reference model: what memory should hold, expected writes, expected pulses.
  typedef struct packed {logic [7:0] addr; logic [31:0] data;} wr_t;
  wr_t         exp_q[$];
  logic [31:0] model_mem [NWORDS];
  logic [31:0] fixed_words [3];
  int          done_exp  = 0;
  int          done_seen = 0;
  bit          in_run    = 1'b0;
  int          checks    = 0;
  int          failures  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the next expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (load_done === 1'b1) done_seen++;
      if (mem_we !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {31'b0, mem_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'b0, mem_addr}, {24'b0, e.addr});
          chk("wr_data", mem_wdata, e.data);
        end
      end
    end
  end

  // Load of n words; optional idle gaps and ignored load_start pokes mid-load.
  task automatic do_load(input int n, input bit gaps, input bit poke, input bit fixed);
    int k;
    logic [31:0] w;
    @(posedge clk); #1;
    load_start = 1'b1;
    load_len   = LEN_W'(n);
    ldif.ld_valid = 1'b0;
    @(negedge clk);
    chk("start_stall", {31'b0, core_stall}, in_run ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    load_start = 1'b0;
    load_len   = LEN_W'($urandom);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        k = fixed ? 2 : int'($urandom_range(0, 2));
        for (int g = 0; g < k; g++) begin
          ldif.ld_valid = 1'b0;
          ldif.ld_data  = $urandom;
          load_start    = poke;
          core_pc       = 8'($urandom);
          @(posedge clk); #1;
          load_start = 1'b0;
        end
      end
      w = fixed ? fixed_words[i] : $urandom;
      ldif.ld_valid = 1'b1;
      ldif.ld_data  = w;
      load_start    = poke && (i == n / 2);
      exp_q.push_back({8'(4 * i), w});
      model_mem[i] = w;
      @(negedge clk);
      chk("busy", {31'b0, load_busy}, 32'd1);
      chk("ready", {31'b0, ldif.ld_ready}, 32'd1);
      chk("stall_in_load", {31'b0, core_stall}, 32'd1);
      chk("nop_in_load", core_instr, NOP);
      @(posedge clk); #1;
      load_start = 1'b0;
    end
    ldif.ld_valid = 1'b0;
    @(negedge clk);
    chk("load_done_pulse", {31'b0, load_done}, 32'd1);
    chk("run_stall", {31'b0, core_stall}, 32'd0);
    chk("run_busy", {31'b0, load_busy}, 32'd0);
    chk("run_ready", {31'b0, ldif.ld_ready}, 32'd0);
    done_exp++;
    in_run = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_done_once", {31'b0, load_done}, 32'd0);
  endtask

  // Combinational fetch in RUN; stray ld_valid must not cause writes.
  task automatic fetch_check(input logic [7:0] pc);
    @(posedge clk); #1;
    core_pc       = pc;
    ldif.ld_valid = 1'($urandom_range(0, 1));
    ldif.ld_data  = $urandom;
    @(negedge clk);
    chk("fetch_addr", {24'b0, mem_addr}, {24'b0, pc[7:2], 2'b00});
    chk("fetch_instr", core_instr, model_mem[pc[7:2]]);
    chk("fetch_stall", {31'b0, core_stall}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < NWORDS; i++) begin
      tb_mem[i]    = 32'd0;
      model_mem[i] = 32'd0;
    end
    fixed_words[0] = 32'h00A0_0093;
    fixed_words[1] = 32'h0010_0023;
    fixed_words[2] = 32'h00A0_0103;
    rst = 1'b1; load_start = 1'b0; load_len = '0; core_pc = '0;
    ldif.ld_valid = 1'b0; ldif.ld_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Boot state: held in IDLE, stray loader words ignored.
    for (int c = 0; c < 10; c++) begin
      ldif.ld_valid = 1'($urandom_range(0, 1));
      ldif.ld_data  = $urandom;
      @(negedge clk);
      chk("idle_stall", {31'b0, core_stall}, 32'd1);
      chk("idle_nop", core_instr, NOP);
      chk("idle_ready", {31'b0, ldif.ld_ready}, 32'd0);
      chk("idle_done", {31'b0, load_done}, 32'd0);
      @(posedge clk); #1;
    end
    ldif.ld_valid = 1'b0;

    do_load(3, 1'b0, 1'b0, 1'b1);
    fetch_check(8'h06);
    do_load(3, 1'b1, 1'b0, 1'b1);
    fetch_check(8'h09);
    do_load(NWORDS, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) fetch_check(8'($urandom));
    fetch_check(8'hFF);

    // Reset after 2 of 5 words: back to IDLE, no load_done, words kept.
    @(posedge clk); #1;
    load_start = 1'b1; load_len = 6'd5; ldif.ld_valid = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      ldif.ld_valid = 1'b1; ldif.ld_data = w;
      exp_q.push_back({8'(4 * i), w});
      model_mem[i] = w;
      @(posedge clk); #1;
    end
    ldif.ld_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_run = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_stall", {31'b0, core_stall}, 32'd1);
      chk("rst_busy", {31'b0, load_busy}, 32'd0);
      chk("rst_nop", core_instr, NOP);
      chk("rst_done", {31'b0, load_done}, 32'd0);
      @(posedge clk); #1;
    end

    do_load(1, 1'b0, 1'b0, 1'b0);
    fetch_check(8'h00);
    fetch_check(8'h05);

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", 32'(done_seen), 32'(done_exp));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Controller for the single-port, word-addressed instruction memory of the single-cycle RISC-V core. It shares the memory port between two requesters: a program-loader stream that writes words sequentially from address 0x00, and core instruction fetch. The core is held stalled and fed NOPs while a load is in progress. Instruction-memory read is combinational, so fetch passes through with zero added latency once the controller is in RUN.

Parameters:
ADDR_W, 8, byte-address width of the instruction memory (word-aligned, step 4)
DATA_W, 32, instruction word width
NOP_INSTR, 32'h0000_0013, instruction driven to the core while stalled (addi x0,x0,0)
BOOT_LOAD, 1, 1: reset state is IDLE (core held until first load); 0: reset state is RUN
LEN_W, ADDR_W-2, width of the word-count field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
load_start  in  1  single-cycle request to begin a program load
load_len  in  LEN_W  number of words to load, sampled with load_start; 0 means 2^LEN_W
ld_valid  in  1  loader word valid
ld_data  in  DATA_W  loader word
ld_ready  out  1  controller accepts a loader word
load_busy  out  1  high while in LOAD
load_done  out  1  one-cycle pulse after the last word is written
core_pc  in  ADDR_W  fetch address from the core
core_instr  out  DATA_W  fetched instruction to the core
core_stall  out  1  core must hold its PC
mem_addr  out  ADDR_W  instruction memory address
mem_we  out  1  instruction memory write enable
mem_wdata  out  DATA_W  instruction memory write data
mem_rdata  in  DATA_W  instruction memory combinational read data

Behaviour:
- States: IDLE, LOAD, RUN. Reset state: IDLE if BOOT_LOAD=1, otherwise RUN.
- Registers: state, wr_addr (ADDR_W), words_left (LEN_W+1), load_done.
- Reset values of outputs:
  - ld_ready=0, load_busy=0, load_done=0, mem_we=0.
  - core_stall=1 and core_instr=NOP_INSTR in IDLE; core_stall=0 in RUN.
- IDLE:
  - core_stall=1, core_instr=NOP_INSTR, mem_addr=0, ld_ready=0.
  - load_start -> LOAD.
- Load entry (from IDLE or RUN), all on the same edge:
  - wr_addr<=0.
  - words_left<=(load_len==0 ? 2^LEN_W : load_len).
- LOAD:
  - load_busy=1, ld_ready=1, core_stall=1, core_instr=NOP_INSTR.
  - mem_addr=wr_addr, mem_wdata=ld_data, mem_we=ld_valid (combinational).
  - On accept (ld_valid & ld_ready): wr_addr<=wr_addr+4, words_left<=words_left-1.
  - Accept with words_left==1 -> RUN, with load_done<=1 for exactly one cycle (the first RUN cycle).
  - ld_valid low stalls the load indefinitely; there is no timeout.
  - load_start while in LOAD is ignored; load_len is not re-sampled.
- RUN:
  - mem_addr={core_pc[ADDR_W-1:2],2'b00}; PC bits [1:0] are ignored.
  - mem_we=0, core_instr=mem_rdata, core_stall=0, ld_ready=0.
  - load_start -> LOAD. In that same cycle the fetch is still served; core_stall rises the next cycle.
- Wrap-around: wr_addr is modulo 2^ADDR_W. A full load of 2^LEN_W words ends exactly at the last word; wr_addr wraps to 0 and is not reused.
- Reset mid-load:
  - Returns to the reset state and clears counters and load_done.
  - Words already written stay in memory. No load_done is produced.
- ld_valid outside LOAD has no effect, and mem_we stays 0.

Decomposition:
- Shared package imem_pkg:
  - state enum imem_ctrl_state_t {IDLE, LOAD, RUN}.
  - constants NOP_INSTR and the word step of 4.
- No sub-module. The FSM, address counter and output mux live in one module that instantiates nothing. The memory array is external.

Test Plan:
- Reset with BOOT_LOAD=1 -> core_stall=1, core_instr=32'h00000013, ld_ready=0, mem_we=0; stays so for 10 cycles with no load_start.
- load_start, load_len=3; words 0x00A00093, 0x00100023, 0x00A00103 sent back-to-back -> writes to addresses 0x00, 0x04, 0x08 on consecutive cycles; load_done pulses once the following cycle; core_stall=0 thereafter.
- Same load with ld_valid low for 2 cycles between words -> mem_we only on valid cycles; addresses still 0x00/0x04/0x08; exactly one load_done.
- In RUN, core_pc=0x06 with memory word at 0x04=0x00100023 -> mem_addr=0x04, core_instr=0x00100023 in the same cycle.
- load_len=0 (64 words) -> last write at 0xFC, then RUN; load_start during the load is ignored (still 64 writes).
- rst asserted after 2 of 5 words -> IDLE next cycle, core_stall=1, no load_done; a new load of 1 word writes address 0x00.
